// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM state type, operand/product widths and per-step shift amounts
package mul_pkg;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  localparam int NIB_W = 4;
  localparam int OP_W = 8;
  localparam int PROD_W = 16;
  localparam logic [3:0] STEP_SH [4] = '{4'd0, 4'd4, 4'd4, 4'd8};
endpackage

// File: rtl/mul4x4_array.sv
// mul4x4_array: combinational 4x4 unsigned array multiplier (a, b -> p = a*b)
module mul4x4_array
  import mul_pkg::*;
(
  input  logic [NIB_W-1:0]   a,
  input  logic [NIB_W-1:0]   b,
  output logic [2*NIB_W-1:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < NIB_W; i++) p = p + ({{NIB_W{1'b0}}, a & {NIB_W{b[i]}}} << i);
  end
endmodule

// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: 8x8 multiply over four 4x4 core steps; in_valid/in_ready/in_a/in_b in, out_valid/out_ready/out_p out, busy
module mul8_seq_ctrl
  import mul_pkg::*;
#(
  parameter bit PP_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p,
  output logic              busy
);
  state_t state_q, state_d;
  logic [OP_W-1:0] a_q, b_q;
  logic [PROD_W-1:0] acc_q, acc_sum;
  logic [1:0] step_q;
  logic ph_q, acc_en, last;
  logic [NIB_W-1:0] core_a, core_b;
  logic [2*NIB_W-1:0] core_p, pp_q, pp_src;
  mul4x4_array u_core (.a(core_a), .b(core_b), .p(core_p));
  always_comb begin
    core_a = state_q == MUL ? (step_q[0] ? a_q[OP_W-1:NIB_W] : a_q[NIB_W-1:0]) : '0;
    core_b = state_q == MUL ? (step_q[1] ? b_q[OP_W-1:NIB_W] : b_q[NIB_W-1:0]) : '0;
    pp_src = PP_REG ? pp_q : core_p;
    acc_sum = acc_q + ({{(PROD_W-2*NIB_W){1'b0}}, pp_src} << STEP_SH[step_q]);
    acc_en = state_q == MUL && (!PP_REG || ph_q);
    last = acc_en && step_q == 2'd3;
    in_ready = state_q == IDLE;
    busy = state_q != IDLE;
    state_d = state_q == IDLE ? (in_valid ? MUL : IDLE) :
              state_q == MUL  ? (last ? DONE : MUL) :
              (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      step_q <= '0;
      ph_q <= 1'b0;
      pp_q <= '0;
      out_p <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        a_q <= in_a;
        b_q <= in_b;
        acc_q <= '0;
        step_q <= '0;
        ph_q <= 1'b0;
      end
      if (state_q == MUL) begin
        pp_q <= core_p;
        ph_q <= PP_REG ? !ph_q : 1'b0;
      end
      if (acc_en) begin
        acc_q <= acc_sum;
        step_q <= step_q + 2'd1;
      end
      if (last) begin
        out_p <= acc_sum;
        out_valid <= 1'b1;
      end
      if (state_q == DONE && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb_mul8_seq_ctrl: directed table, corner sequences and random products for both PP_REG builds
module tb_mul8_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic in_valid [2], in_ready [2], out_valid [2], out_ready [2], busy [2];
  logic [7:0] in_a [2], in_b [2];
  logic [15:0] out_p [2];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mul8_seq_ctrl #(.PP_REG(g == 1)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_a(in_a[g]), .in_b(in_b[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_p(out_p[g]), .busy(busy[g])
    );
  end
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int stall;
    logic [15:0] p;
  } vec_t;
  vec_t vecs [5];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                        input int stall, input bit rnd, input logic [15:0] exp);
    int n;
    logic [15:0] held;
    chk("in_ready_idle", in_ready[d], 1);
    in_valid[d] = 1'b1;
    in_a[d] = a;
    in_b[d] = b;
    out_ready[d] = 1'b0;
    @(negedge clk);
    in_valid[d] = 1'b0;
    chk("busy_after_accept", {busy[d], in_ready[d]}, 2'b10);
    n = 1;
    while (!out_valid[d] && n < 40) begin
      out_ready[d] = rnd ? 1'($urandom % 2) : 1'b0;
      in_a[d] = 8'($urandom);
      in_b[d] = 8'($urandom);
      @(negedge clk);
      n++;
    end
    out_ready[d] = 1'b0;
    chk("latency", n, 1 + 4 * (1 + d));
    if (!out_valid[d]) return;
    held = out_p[d];
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_hold", {out_valid[d], in_ready[d], out_p[d]}, {1'b1, 1'b0, held});
    end
    chk("product", out_p[d], exp);
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk("release", {out_valid[d], in_ready[d], busy[d]}, 3'b010);
  endtask
  initial begin
    int accepts;
    bit seen_valid;
    logic [15:0] prods [$];
    logic [7:0] ra, rb;
    vecs[0] = '{8'h12, 8'h34, 0, 16'h03A8};
    vecs[1] = '{8'hFF, 8'hFF, 1, 16'hFE01};
    vecs[2] = '{8'h00, 8'hA7, 0, 16'h0000};
    vecs[3] = '{8'hA5, 8'h3C, 10, 16'h26AC};
    vecs[4] = '{8'h07, 8'h09, 2, 16'h003F};
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b0;
      in_a[d] = '0;
      in_b[d] = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk("reset_state", {out_valid[d], out_p[d], in_ready[d], busy[d]}, {1'b0, 16'h0000, 1'b1, 1'b0});
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 5; i++) run_op(d, vecs[i].a, vecs[i].b, vecs[i].stall, 1'b0, vecs[i].p);
    in_valid[0] = 1'b1;
    in_a[0] = 8'h0F;
    in_b[0] = 8'h0F;
    out_ready[0] = 1'b1;
    accepts = 0;
    for (int c = 0; c < 30; c++) begin
      if (in_valid[0] && in_ready[0]) accepts++;
      if (out_valid[0]) prods.push_back(out_p[0]);
      @(negedge clk);
      if (accepts == 1) begin
        in_a[0] = 8'h80;
        in_b[0] = 8'h02;
      end
      if (accepts == 2) in_valid[0] = 1'b0;
    end
    out_ready[0] = 1'b0;
    chk("b2b_accepts", accepts, 2);
    chk("b2b_count", prods.size(), 2);
    if (prods.size() == 2) begin
      chk("b2b_first", prods[0], 16'h00E1);
      chk("b2b_second", prods[1], 16'h0100);
    end
    in_valid[0] = 1'b1;
    in_a[0] = 8'h12;
    in_b[0] = 8'h34;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_idle", {busy[0], out_valid[0], in_ready[0]}, 3'b001);
    seen_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid[0]) seen_valid = 1'b1;
    end
    chk("abort_no_output", seen_valid, 0);
    run_op(0, 8'h07, 8'h09, 0, 1'b0, 16'h003F);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 1000; i++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        run_op(d, ra, rb, int'($urandom_range(0, 3)), 1'b1, 16'(ra) * 16'(rb));
      end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
